// File: rtl/data_receiver.sv
// Serial receiver: eight LSB-first bytes per 64-bit word, with an ack/overrun handshake.
// Optional inter-byte timeout is enabled by defining RECEIVER_TIMEOUT_EN.
module data_receiver #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transmission,
  input  logic        clock,
  input  logic        in_data,
  input  logic        ack,
  output logic [63:0] data,
  output logic        valid,
  output logic        busy,
  output logic        frame_error,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  trans_sync_q;
  logic [1:0]  clock_sync_q;
  logic [1:0]  din_sync_q;
  logic        clock_prev_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  byte_idx_q;
  logic [7:0]  shift_q;
  logic [55:0] word_q;
  logic [63:0] data_q;
  logic        valid_q;
  logic        busy_q;
  logic        frame_error_q;
  logic        overrun_q;

  logic        bit_event_d;
  logic        abort_d;
  logic        discard_d;
  logic [7:0]  byte_d;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("data_receiver: TIMEOUT must be at least 1");
  end

  assign bit_event_d = clock_sync_q[1] & ~clock_prev_q & trans_sync_q[1];
  assign byte_d      = {din_sync_q[1], shift_q[7:1]};
  // Transmission can only be high on entry to RECV, so a low level here is its falling edge.
  assign abort_d     = (state_q == RECV) && !trans_sync_q[1];

`ifdef RECEIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit_d;

  assign tmo_hit_d = (state_q != IDLE) && !bit_event_d && (tmo_q == TW'(TIMEOUT - 1));
  assign discard_d = abort_d | tmo_hit_d;

  // Stall counter: cycles in GAP, or in RECV without a bit event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if ((state_q == IDLE) || bit_event_d || discard_d) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign discard_d = abort_d;
`endif

  // Synchronizers, receive FSM, word assembly and output handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trans_sync_q  <= 2'b00;
      clock_sync_q  <= 2'b00;
      din_sync_q    <= 2'b00;
      clock_prev_q  <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      byte_idx_q    <= 3'd0;
      shift_q       <= 8'h00;
      word_q        <= 56'h0;
      data_q        <= 64'h0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      trans_sync_q  <= {trans_sync_q[0], transmission};
      clock_sync_q  <= {clock_sync_q[0], clock};
      din_sync_q    <= {din_sync_q[0], in_data};
      clock_prev_q  <= clock_sync_q[1];
      frame_error_q <= 1'b0;

      if (ack && valid_q) begin
        valid_q <= 1'b0;
      end

      if (discard_d) begin
        state_q       <= IDLE;
        busy_q        <= 1'b0;
        bit_cnt_q     <= 3'd0;
        byte_idx_q    <= 3'd0;
        shift_q       <= 8'h00;
        frame_error_q <= 1'b1;
      end else if (bit_event_d) begin
        shift_q   <= byte_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_idx_q == 3'd7) begin
            // A completion wins over a same-cycle ack; only an unacked replacement is an overrun.
            data_q     <= {byte_d, word_q};
            valid_q    <= 1'b1;
            if (valid_q && !ack) begin
              overrun_q <= 1'b1;
            end
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            byte_idx_q <= 3'd0;
          end else begin
            for (int k = 0; k < 7; k++) begin
              if (byte_idx_q == 3'(k)) begin
                word_q[8*k +: 8] <= byte_d;
              end
            end
            byte_idx_q <= byte_idx_q + 3'd1;
            state_q    <= GAP;
            busy_q     <= 1'b1;
          end
        end else begin
          state_q <= RECV;
          busy_q  <= 1'b1;
        end
      end
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_data_receiver.sv
// Self-checking bench for data_receiver: vector table, directed corner sequences, randomized words.
module tb_data_receiver;
`ifdef RECEIVER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        transmission;
  logic        clock;
  logic        in_data;
  logic        ack;
  logic [63:0] data;
  logic        valid;
  logic        busy;
  logic        frame_error;
  logic        overrun;

  data_receiver #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock),
    .in_data(in_data), .ack(ack), .data(data), .valid(valid),
    .busy(busy), .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int busy_seen = 0;

  logic [63:0] m_data;
  bit          m_valid;
  bit          m_ovr;
  int          m_fe;

  always @(posedge clk) begin
    #1;
    if (frame_error === 1'b1) fe_seen++;
    if (busy === 1'b1) busy_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic m_word(input logic [63:0] w, input bit coincide);
    if (m_valid && !coincide) m_ovr = 1'b1;
    m_data  = w;
    m_valid = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, data, m_data);
    check({tag, "_valid"}, {63'd0, valid}, {63'd0, m_valid});
    check({tag, "_overrun"}, {63'd0, overrun}, {63'd0, m_ovr});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_fe_count"}, 64'(fe_seen), 64'(m_fe));
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; transmission = 1'b0; clock = 1'b0; in_data = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_data = 64'h0; m_valid = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int h, input bit coincide, input bit probe);
    int hh;
    in_data = b;
    clock = 1'b0;
    repeat (h) @(negedge clk);
    clock = 1'b1;
    hh = ((coincide || probe) && h < 3) ? 3 : h;
    for (int c = 1; c <= hh; c++) begin
      @(negedge clk);
      if (coincide && c == 2) ack = 1'b1;
      if (coincide && c == 3) ack = 1'b0;
      if (probe && c == 2) check("valid_latency_2", {63'd0, valid}, 64'd0);
      if (probe && c == 3) check("valid_latency_3", {63'd0, valid}, 64'd1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int h, input int gap, input bit coincide, input bit probe);
    transmission = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(b[i], h, coincide && (i == 7), probe && (i == 7));
    clock = 1'b0;
    repeat (h) @(negedge clk);
    transmission = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w, input int h, input int gap, input bit coincide, input bit probe);
    for (int b = 0; b < 8; b++) send_byte(w[8*b +: 8], h, gap, coincide && (b == 7), probe && (b == 7));
  endtask

  task automatic send_partial(input logic [63:0] w, input int nbytes, input int nbits, input int h);
    for (int b = 0; b < nbytes; b++) send_byte(w[8*b +: 8], h, 2, 1'b0, 1'b0);
    transmission = 1'b1;
    for (int i = 0; i < nbits; i++) send_bit(w[8*nbytes + i], h, 1'b0, 1'b0);
    clock = 1'b0;
    repeat (h) @(negedge clk);
    transmission = 1'b0;
  endtask

  typedef struct {
    bit          send;
    logic [63:0] word;
    bit          do_ack;
    bit          probe;
    logic [63:0] exp_data;
    bit          exp_valid;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy_before;
    logic [63:0] w;
    bit co;
    int h, gap;

    vecs[0] = '{1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'h0000000000000001, 1'b0, 1'b0, 64'h0000000000000001, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 64'h0000000000000002, 1'b0, 1'b0, 64'h0000000000000002, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 64'h0000000000000000, 1'b1, 1'b0, 64'h0000000000000002, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 64'h5A5A0F0F3C3C9696, 1'b0, 1'b0, 64'h5A5A0F0F3C3C9696, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 64'h0000000000000000, 1'b1, 1'b0, 64'h5A5A0F0F3C3C9696, 1'b0, 1'b1};

    rst = 1'b0; transmission = 1'b0; clock = 1'b0; in_data = 1'b0; ack = 1'b0;
    m_data = 64'h0; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 0;
    repeat (3) @(negedge clk);
    check_state("reset");
    check("reset_fe", {63'd0, frame_error}, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Vector table: word sequences with expected data/valid/overrun.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].send) begin
        send_word(vecs[i].word, 2, 2, 1'b0, vecs[i].probe);
        settle();
        check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
        check($sformatf("vec%0d_valid_pre", i), {63'd0, valid}, 64'd1);
        m_word(vecs[i].word, 1'b0);
      end
      if (vecs[i].do_ack) begin
        repeat (5) @(negedge clk);
        check($sformatf("vec%0d_valid_before_ack", i), {63'd0, valid}, 64'd1);
        do_ack();
        check($sformatf("vec%0d_valid_after_ack", i), {63'd0, valid}, 64'd0);
      end
      settle();
      check($sformatf("vec%0d_data_end", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_valid_end", i), {63'd0, valid}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_overrun", i), {63'd0, overrun}, {63'd0, vecs[i].exp_ovr});
      check($sformatf("vec%0d_fe", i), 64'(fe_seen), 64'd0);
    end

    // Abort after 3 bits of byte 4 while a word is held.
    send_word(64'hDEADBEEFCAFEF00D, 2, 2, 1'b0, 1'b0);
    m_word(64'hDEADBEEFCAFEF00D, 1'b0);
    settle();
    send_partial(64'h1234567812345678, 4, 3, 2);
    m_fe++;
    settle();
    check_state("abort");
    send_word(64'hFFFF0000FFFF0000, 2, 2, 1'b0, 1'b0);
    m_word(64'hFFFF0000FFFF0000, 1'b0);
    settle();
    check_state("after_abort");
    do_ack();
    settle();

    // Long stall in GAP after byte 2.
    w = 64'h1122334455667788;
    for (int b = 0; b < 3; b++) send_byte(w[8*b +: 8], 2, 2, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
`ifdef RECEIVER_TIMEOUT_EN
    m_fe++;
    check_state("timeout");
    send_word(w, 2, 2, 1'b0, 1'b0);
`else
    check("stall_busy", {63'd0, busy}, 64'd1);
    check("stall_fe", 64'(fe_seen), 64'(m_fe));
    for (int b = 3; b < 8; b++) send_byte(w[8*b +: 8], 2, 2, 1'b0, 1'b0);
`endif
    m_word(w, 1'b0);
    settle();
    check_state("stall_word");

    // Reset in the middle of byte 5.
    send_partial(64'h0F1E2D3C4B5A6978, 5, 4, 2);
    do_reset();
    check_state("midreset");
    check("midreset_fe", {63'd0, frame_error}, 64'd0);
    send_word(64'hA5A5A5A5A5A5A5A5, 2, 2, 1'b0, 1'b0);
    m_word(64'hA5A5A5A5A5A5A5A5, 1'b0);
    settle();
    check_state("after_reset");

    // Clock toggles with transmission low must be ignored.
    busy_before = busy_seen;
    transmission = 1'b0;
    for (int e = 0; e < 100; e++) begin
      clock = ~clock;
      in_data = 1'($urandom);
      @(negedge clk);
    end
    clock = 1'b0;
    settle();
    check("idle_toggle_busy", 64'(busy_seen - busy_before), 64'd0);
    check_state("idle_toggle");

    // Randomized words, aborts, coincident and late acks.
    for (int it = 0; it < 24; it++) begin
      h = $urandom_range(1, 3);
      gap = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) begin
        w = {$urandom, $urandom};
        send_partial(w, $urandom_range(0, 7), $urandom_range(1, 7), h);
        m_fe++;
      end else begin
        w = {$urandom, $urandom};
        co = ($urandom_range(0, 3) == 0);
        send_word(w, h, gap, co, 1'b0);
        m_word(w, co);
        if ($urandom_range(0, 1) == 1) begin
          settle();
          do_ack();
        end
      end
      settle();
      check_state($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
